io_corner_cfg_bank: RTL and testbench

Parametrised configuration-memory bank for multi-channel I/O corner tiles. It replaces per-channel clock-mux memories with one checked configuration-chain segment. The chain shifts a bitstream in on `prog_clock` and holds it in a shadow register. It commits the bitstream to the active `mem_out` word only when exactly the expected number of bits arrived, so a truncated or overlong load never reaches the fabric. The block sits between the tile's `ccff_head`/`ccff_tail` pins and the per-channel clock-select muxes and mode bits of each iopad.

---
 rtl/io_corner_cfg_pkg.sv | 26 ++
 rtl/io_corner_cfg_shadow.sv | 34 +++
 rtl/io_corner_cfg_bank.sv | 97 +++++++++
 tb/tb_io_corner_cfg_bank.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/io_corner_cfg_pkg.sv
// Shared types and helpers for the I/O corner configuration bank.
// Provides the load FSM state enum, the chain-length function and the per-channel field offsets.
// Channel c occupies [c*(SEL_BITS+MODE_BITS) +: SEL_BITS+MODE_BITS], with the select field in the low bits.
package io_corner_cfg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cfg_state_e;

  // Total configuration chain length for one corner tile.
  function automatic int cfg_chain_len(input int num_ch, input int sel_bits, input int mode_bits);
    return num_ch * (sel_bits + mode_bits);
  endfunction

  // LSB of channel ch's clock-select field inside mem_out.
  function automatic int cfg_sel_lsb(input int ch, input int sel_bits, input int mode_bits);
    return ch * (sel_bits + mode_bits);
  endfunction

  // LSB of channel ch's mode field; it sits directly above the select field.
  function automatic int cfg_mode_lsb(input int ch, input int sel_bits, input int mode_bits);
    return ch * (sel_bits + mode_bits) + sel_bits;
  endfunction

endpackage

// File: rtl/io_corner_cfg_shadow.sv
// Shadow shift register of the configuration chain, plus the registered ccff_tail stage.
// Ports: prog_clock/global_reset (async active-low), i_shift_en, i_ccff_head in;
//        o_shadow (L bits) and o_ccff_tail out. Head-to-tail latency is L+1 register stages.
module io_corner_cfg_shadow #(
  parameter int L = 12
) (
  input  logic         prog_clock,
  input  logic         global_reset,
  input  logic         i_shift_en,
  input  logic         i_ccff_head,
  output logic [L-1:0] o_shadow,
  output logic         o_ccff_tail
);

  logic [L-1:0] r_shadow;
  logic         r_tail;

  // New bits enter at bit 0 and move toward L-1, so the first bit of a
  // full-length load lands in bit L-1. The stage that falls off the top is
  // captured into r_tail, which lets surplus bits continue to the next tile.
  always_ff @(posedge prog_clock or negedge global_reset) begin
    if (!global_reset) begin
      r_shadow <= '0;
      r_tail   <= 1'b0;
    end else if (i_shift_en) begin
      r_shadow <= {r_shadow[L-2:0], i_ccff_head};
      r_tail   <= r_shadow[L-1];
    end
  end

  assign o_shadow    = r_shadow;
  assign o_ccff_tail = r_tail;

endmodule

// File: rtl/io_corner_cfg_bank.sv
// Checked configuration-chain segment for an I/O corner tile; commits the shadow word to mem_out
// only when exactly L bits were shifted in a window. Ports: prog_clock, global_reset (async, active-low),
// config_enable, ccff_head in; ccff_tail, mem_out, mem_outb, cfg_done, cfg_error, bit_count out.
module io_corner_cfg_bank
  import io_corner_cfg_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int SEL_BITS  = 4,
  parameter  int MODE_BITS = 2,
  localparam int L         = cfg_chain_len(NUM_CH, SEL_BITS, MODE_BITS),
  localparam int CW        = $clog2(L + 2)
) (
  input  logic          prog_clock,
  input  logic          global_reset,
  input  logic          config_enable,
  input  logic          ccff_head,
  output logic          ccff_tail,
  output logic [L-1:0]  mem_out,
  output logic [L-1:0]  mem_outb,
  output logic          cfg_done,
  output logic          cfg_error,
  output logic [CW-1:0] bit_count
);

  localparam logic [CW-1:0] CNT_FULL = CW'(L);
  localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

  cfg_state_e    r_state;
  logic [L-1:0]  r_mem_out;
  logic [L-1:0]  r_mem_outb;
  logic [CW-1:0] r_bit_count;
  logic          r_cfg_done;
  logic          r_cfg_error;
  logic [L-1:0]  w_shadow;

  // Shifting happens on exactly the edges where config_enable is high: the
  // first bit of a window shifts on the IDLE->SHIFT edge and the closing
  // edge (enable low) shifts nothing.
  io_corner_cfg_shadow #(
    .L (L)
  ) u_shadow (
    .prog_clock   (prog_clock),
    .global_reset (global_reset),
    .i_shift_en   (config_enable),
    .i_ccff_head  (ccff_head),
    .o_shadow     (w_shadow),
    .o_ccff_tail  (ccff_tail)
  );

  always_ff @(posedge prog_clock or negedge global_reset) begin
    if (!global_reset) begin
      r_state     <= IDLE;
      r_mem_out   <= '0;
      r_mem_outb  <= '1;
      r_bit_count <= '0;
      r_cfg_done  <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (config_enable) begin
            r_state     <= SHIFT;
            r_bit_count <= CW'(1);
            r_cfg_error <= 1'b0;
          end
        end
        SHIFT: begin
          if (config_enable) begin
            // Saturate one past L so an overlong load stays distinguishable
            // from an exact one without ever wrapping back to L.
            if (r_bit_count != CNT_SAT) begin
              r_bit_count <= r_bit_count + CW'(1);
            end
          end else begin
            r_state <= IDLE;
            if (r_bit_count == CNT_FULL) begin
              r_mem_out  <= w_shadow;
              r_mem_outb <= ~w_shadow;
              r_cfg_done <= 1'b1;
            end else begin
              r_cfg_error <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_out   = r_mem_out;
  assign mem_outb  = r_mem_outb;
  assign cfg_done  = r_cfg_done;
  assign cfg_error = r_cfg_error;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_io_corner_cfg_bank.sv
// Directed bench for io_corner_cfg_bank with NUM_CH=2, SEL_BITS=4, MODE_BITS=2 (L=12).
// Inputs change just after the falling edge; outputs are checked on the falling edge.
// Expected values are hand-computed constants.
module tb_io_corner_cfg_bank;

  logic        prog_clock = 1'b0;
  logic        global_reset;
  logic        config_enable;
  logic        ccff_head;
  logic        ccff_tail;
  logic [11:0] mem_out;
  logic [11:0] mem_outb;
  logic        cfg_done;
  logic        cfg_error;
  logic [3:0]  bit_count;

  int errors = 0;
  int checks = 0;

  always #5 prog_clock = ~prog_clock;

  io_corner_cfg_bank #(
    .NUM_CH    (2),
    .SEL_BITS  (4),
    .MODE_BITS (2)
  ) dut (
    .prog_clock    (prog_clock),
    .global_reset  (global_reset),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .mem_out       (mem_out),
    .mem_outb      (mem_outb),
    .cfg_done      (cfg_done),
    .cfg_error     (cfg_error),
    .bit_count     (bit_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic tick();
    @(posedge prog_clock);
    @(negedge prog_clock);
  endtask

  // Shift n bits of val, most significant first, with the window open.
  task automatic shift_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      config_enable = 1'b1;
      ccff_head     = val[i];
      tick();
    end
  endtask

  logic [13:0] long_word;

  initial begin
    global_reset  = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    @(negedge prog_clock);
    @(negedge prog_clock);
    global_reset = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) tick();
    check("rst_mem_out",  32'(mem_out),   32'h000);
    check("rst_mem_outb", 32'(mem_outb),  32'hFFF);
    check("rst_done",     32'(cfg_done),  32'd0);
    check("rst_error",    32'(cfg_error), 32'd0);
    check("rst_count",    32'(bit_count), 32'd0);
    check("rst_tail",     32'(ccff_tail), 32'd0);

    // 2: exact 12-bit load of 0xB3A
    shift_bits(32'hB3A, 12);
    check("s2_count_12",       32'(bit_count), 32'd12);
    check("s2_mem_hold_shift", 32'(mem_out),   32'h000);
    config_enable = 1'b0;
    tick();
    check("s2_done_pulse", 32'(cfg_done),  32'd1);
    check("s2_mem_out",    32'(mem_out),   32'hB3A);
    check("s2_mem_outb",   32'(mem_outb),  32'h4C5);
    check("s2_error",      32'(cfg_error), 32'd0);
    tick();
    check("s2_done_drop",  32'(cfg_done),  32'd0);

    // 3: truncated 11-bit load is rejected
    shift_bits(32'h123, 11);
    config_enable = 1'b0;
    tick();
    check("s3_error_set", 32'(cfg_error), 32'd1);
    check("s3_no_done",   32'(cfg_done),  32'd0);
    check("s3_mem_hold",  32'(mem_out),   32'hB3A);
    tick();

    // 4: overlong 14-bit window (0xB3A then bits 0,1); opening it clears the error
    long_word = {12'hB3A, 2'b01};
    for (int i = 13; i >= 0; i--) begin
      config_enable = 1'b1;
      ccff_head     = long_word[i];
      tick();
      if (i == 13) begin
        check("s3_error_clear", 32'(cfg_error), 32'd0);
        check("s4_count_1",     32'(bit_count), 32'd1);
      end
      if (i == 1) begin
        check("s4_tail_bit1",   32'(ccff_tail), 32'd1);
        check("s4_count_13",    32'(bit_count), 32'd13);
      end
      if (i == 0) begin
        check("s4_tail_bit2",   32'(ccff_tail), 32'd0);
        check("s4_count_sat",   32'(bit_count), 32'd13);
      end
    end
    config_enable = 1'b0;
    tick();
    check("s4_error",   32'(cfg_error), 32'd1);
    check("s4_no_done", 32'(cfg_done),  32'd0);
    check("s4_mem",     32'(mem_out),   32'hB3A);
    tick();

    // 5: reset in the middle of a load, then a clean reload of 0x5A5
    shift_bits(32'h5A5 >> 6, 6);
    check("s5_count_6", 32'(bit_count), 32'd6);
    global_reset  = 1'b0;
    config_enable = 1'b0;
    #1;
    check("s5_rst_mem",   32'(mem_out),   32'h000);
    check("s5_rst_memb",  32'(mem_outb),  32'hFFF);
    check("s5_rst_count", 32'(bit_count), 32'd0);
    check("s5_rst_error", 32'(cfg_error), 32'd0);
    check("s5_rst_tail",  32'(ccff_tail), 32'd0);
    check("s5_rst_done",  32'(cfg_done),  32'd0);
    @(negedge prog_clock);
    global_reset = 1'b1;
    tick();
    shift_bits(32'h5A5, 12);
    config_enable = 1'b0;
    tick();
    check("s5_done", 32'(cfg_done), 32'd1);
    check("s5_mem",  32'(mem_out),  32'h5A5);
    check("s5_memb", 32'(mem_outb), 32'hA5A);
    tick();

    // 6: back-to-back windows with a one-cycle gap
    shift_bits(32'h0F0, 12);
    config_enable = 1'b0;
    tick();
    check("s6_done_a", 32'(cfg_done), 32'd1);
    check("s6_mem_a",  32'(mem_out),  32'h0F0);
    shift_bits(32'hF0F >> 11, 1);
    check("s6_done_a_drop", 32'(cfg_done),  32'd0);
    check("s6_count_1",     32'(bit_count), 32'd1);
    check("s6_mem_hold1",   32'(mem_out),   32'h0F0);
    shift_bits(32'hF0F, 11);
    check("s6_mem_hold2",   32'(mem_out),   32'h0F0);
    config_enable = 1'b0;
    tick();
    check("s6_done_b", 32'(cfg_done),  32'd1);
    check("s6_mem_b",  32'(mem_out),   32'hF0F);
    check("s6_memb_b", 32'(mem_outb),  32'h0F0);
    check("s6_error",  32'(cfg_error), 32'd0);
    tick();
    check("s6_done_b_drop", 32'(cfg_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
